// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, 8N1/8N2 with one-byte holding register for back-to-back frames.
// Define UART_TX_PARITY_EN to insert a parity bit after data bit 7 (sense set by PARITY_ODD).
module uart_tx #(
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       busy,
  output logic       tx_done
);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} state_t;
`else
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} state_t;
`endif
  if (STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_param
    $error("uart_tx: STOP_BITS must be 1 or 2 and PARITY_ODD 0 or 1");
  end
  state_t     state_q, state_d;
  logic [7:0] hold_q, hold_d, shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       hold_full_q, hold_full_d, stop_cnt_q, stop_cnt_d;
  logic       tx_q, tx_d, done_q, done_d, accept, load;
`ifdef UART_TX_PARITY_EN
  logic       par_q, par_d;
`endif
  assign accept      = data_valid && !hold_full_q;
  assign hold_d      = accept ? data_in : hold_q;
  assign hold_full_d = accept | (hold_full_q & ~load);
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (baud_tick) begin
      case (state_q)
        TX_IDLE: begin
          load    = hold_full_q;
          tx_d    = !hold_full_q;
          state_d = hold_full_q ? TX_START : TX_IDLE;
        end
        TX_START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = 3'd0;
          state_d   = TX_DATA;
        end
        TX_DATA: begin
          if (bit_cnt_q != 3'd7) begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d       = par_q;
            state_d    = TX_PARITY;
`else
            tx_d       = 1'b1;
            stop_cnt_d = 1'b0;
            state_d    = TX_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = TX_STOP;
        end
`endif
        TX_STOP: begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            done_d  = 1'b1;
            load    = hold_full_q;
            tx_d    = !hold_full_q;
            state_d = hold_full_q ? TX_START : TX_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + 1'b1;
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
    if (load) shift_d = hold_q;
  end
`ifdef UART_TX_PARITY_EN
  // parity is taken at load time because the shift register is consumed while sending
  assign par_d = load ? (^hold_q ^ 1'(PARITY_ODD)) : par_q;
  always_ff @(posedge clk) par_q <= rst ? 1'b0 : par_d;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= TX_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      stop_cnt_q  <= stop_cnt_d;
      tx_q        <= tx_d;
      done_q      <= done_d;
    end
  end
  assign tx_ready = !hold_full_q;
  assign tx       = tx_q;
  assign tx_done  = done_q;
  assign busy     = (state_q != TX_IDLE) || hold_full_q;
endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter for the register access path. It takes 8-bit parallel bytes from the response/formatter logic over a valid/ready handshake and shifts them out on the `tx` line toward the Raspberry Pi. The frame is LSB first: 1 start bit, 8 data bits, an optional parity bit, and 1 or 2 stop bits. Bit timing comes from the shared baud generator's `baud_tick` strobe, the same one the receive side uses. A one-byte holding register in front of the shift register allows back-to-back frames with no idle gap.

## Interface
- `STOP_BITS`, default 1: number of stop bits; legal values are 1 and 2.
- `PARITY_ODD`, default 0: selects the parity sense, 0 = even, 1 = odd. It only has an effect when `UART_TX_PARITY_EN` is defined.
- `clk` input, 1 bit: system clock.
- `rst` input, 1 bit: reset, synchronous to `clk` and active-high.
- `baud_tick` input, 1 bit: one-`clk` pulse per bit period from the baud generator.
- `data_in` input, 8 bits: byte to transmit; sampled on handshake.
- `data_valid` input, 1 bit: `data_in` is valid.
- `tx_ready` output, 1 bit: the holding register is empty and the block can accept a byte.
- `tx` output, 1 bit: UART serial line; idles high.
- `busy` output, 1 bit: a frame is in progress or a byte is held.
- `tx_done` output, 1 bit: one-`clk` pulse at the end of each frame's final stop bit.

## Operation
- **Handshake.** A byte is accepted on any `clk` edge where `data_valid && tx_ready`.
  - On acceptance, `data_in` is copied into the holding register and `hold_full` is set.
  - `tx_ready = !hold_full`, decoded from a register with no combinational path from `data_valid`.
  - `data_valid` while `tx_ready=0` is ignored. The source must hold the byte until it is accepted.
- **State machine.** States are TX_IDLE, TX_START, TX_DATA, TX_PARITY (present only when parity is compiled in) and TX_STOP. All transitions occur only on `clk` edges where `baud_tick=1`.
- **TX_IDLE.** On a tick with `hold_full=1`:
  - load the shift register from the holding register and clear `hold_full`;
  - set `tx<=0` and go to TX_START.
  - On a tick without a held byte, stay in TX_IDLE with `tx=1`.
- **TX_START.** On the next tick: `tx<=shift[0]`, `bit_cnt<=0`, go to TX_DATA.
- **TX_DATA.** On each tick:
  - if `bit_cnt<7`: shift right, `tx<=` next bit, increment `bit_cnt`;
  - if `bit_cnt==7`: go to TX_PARITY with `tx<=`parity bit, or go to TX_STOP with `tx<=1` when parity is not compiled in.
  - `bit_cnt` is 3 bits wide and never wraps within a frame.
- **TX_PARITY.** On the next tick: `tx<=1`, go to TX_STOP, clear `stop_cnt`.
- **TX_STOP.** Lasts `STOP_BITS` ticks, counted by `stop_cnt`. On the tick that ends the last stop bit:
  - pulse `tx_done`;
  - if `hold_full=1`, load the next byte, set `tx<=0` and go to TX_START (back-to-back, no idle bit);
  - otherwise go to TX_IDLE with `tx` staying at 1.
- **Concurrent events.** Acceptance requires `hold_full=0`; unload requires `hold_full=1`. The two are mutually exclusive in a given cycle, so no conflict exists. A byte can be accepted during any state, including mid-frame.
- **`busy`** = `(state != TX_IDLE) || hold_full`, registered or decoded from registers.
- **Reset.** `rst` mid-frame aborts the frame. On the next edge:
  - `tx=1`, the state returns to TX_IDLE;
  - the holding and shift registers are cleared and any held byte is discarded;
  - no `tx_done` is generated.

## Timing
- **Reset values:** `tx=1`, `tx_ready=1`, `busy=0`, `tx_done=0`; the state is TX_IDLE.
- **Latency.** A byte accepted at edge t starts on the first `baud_tick` edge strictly after t. A tick in the same cycle as acceptance does not start the frame. `tx` falls on that tick's edge.
- **Bit period.** Each bit is held for exactly one tick-to-tick interval.
- **Frame length in ticks:** 1 + 8 + P + `STOP_BITS`, where P = 1 if parity is compiled in, else 0. The default build is 10 ticks.
- **`tx_ready` re-assertion.** `tx_ready` rises on the edge that unloads the holding register, either the TX_IDLE start tick or the final stop tick.
- **`tx_done`** is high for exactly one `clk`, coincident with the final stop tick edge.
- **Output glitches.** `tx` is driven directly from a flop, with no glitches.

## Configuration
- **`UART_TX_PARITY_EN` defined:** the TX_PARITY state exists.
  - The parity bit is the XOR of the 8 data bits when `PARITY_ODD=0`, and its inverse when `PARITY_ODD=1`.
  - It is sent after data bit 7.
- **`UART_TX_PARITY_EN` not defined:** the TX_PARITY state and parity logic are absent, TX_DATA goes directly to TX_STOP, and `PARITY_ODD` is ignored.

## Test plan
- **Single byte.** Reset, send `data_in=0x55`, ticks every 16 clk. Expect `tx` = 0,1,0,1,0,1,0,1,0,1 over 10 tick periods, then idle at 1. Expect one `tx_done` pulse and `busy` low after the frame.
- **Back-to-back.** Send 0xA3, then offer 0x3C as soon as `tx_ready` rises. Expect the 0xA3 stop bit to be followed immediately by the 0x3C start bit with no idle period. Expect exactly 2 `tx_done` pulses and `tx_ready=0` while both bytes are pending.
- **Backpressure.** Hold `data_valid=1` with 0x11, then 0x22, then 0x33. Expect a byte to be accepted only on `tx_ready=1` cycles, with the wire carrying 0x11, 0x22, 0x33 in order and none dropped or duplicated.
- **Reset mid-frame.** Assert `rst` for 1 clk during data bit 4 of 0xF0 while 0x0F is held. Expect `tx=1` on the next edge, no `tx_done`, `tx_ready=1`, `busy=0`, and 0x0F not transmitted.
- **Parity (`UART_TX_PARITY_EN`).** Send 0x07 with `PARITY_ODD=0` and expect a parity bit of 1. With `PARITY_ODD=1`, expect 0. Each frame is 11 ticks.
- **`STOP_BITS=2`.** Send 0x80. Expect bit 7 = 1, then `tx=1` for 2 tick periods, with `tx_done` on the end of the second stop bit.
